// File: rtl/axi_ram_pkg.sv
// axi_ram_pkg: shared types for the AXI4 RAM responder
package axi_ram_pkg;
    typedef enum logic [2:0] {IDLE, WR, WRESP, RFETCH, RDATA} state_t;
endpackage

// File: rtl/axi_ram_slave_ram.sv
// ram_sp_sync: single-port synchronous RAM, registered read, write-first
module ram_sp_sync #(
    parameter int D_WIDTH    = 16,
    parameter int MEM_AWIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [MEM_AWIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0]    wdata,
    output logic [D_WIDTH-1:0]    rdata
);
    logic [D_WIDTH-1:0] mem [1<<MEM_AWIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 INCR-burst responder backed by on-chip synchronous RAM
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int A_WIDTH    = 26,
    parameter int D_WIDTH    = 16,
    parameter int D_LEVEL    = 1,
    parameter int MEM_AWIDTH = 10
) (
    input  logic               rstn,
    input  logic               clk,
    input  logic               awvalid,
    output logic               awready,
    input  logic [A_WIDTH-1:0] awaddr,
    input  logic [7:0]         awlen,
    input  logic               wvalid,
    output logic               wready,
    input  logic               wlast,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               bvalid,
    input  logic               bready,
    input  logic               arvalid,
    output logic               arready,
    input  logic [A_WIDTH-1:0] araddr,
    input  logic [7:0]         arlen,
    output logic               rvalid,
    input  logic               rready,
    output logic               rlast,
    output logic [D_WIDTH-1:0] rdata,
    output logic               wlast_err
);
    state_t                stat;
    logic [MEM_AWIDTH-1:0] ptr;
    logic [7:0]            len, cnt;
    logic                  awready_q, wready_q, rvalid_q, rlast_q;
    logic [D_WIDTH-1:0]    ram_q;
    logic                  unused_addr;

    assign unused_addr = ^{awaddr, araddr};
    assign awready = awready_q;
    assign arready = awready_q & ~awvalid;
    assign wready  = wready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rvalid_q ? ram_q : '0;

    ram_sp_sync #(.D_WIDTH(D_WIDTH), .MEM_AWIDTH(MEM_AWIDTH)) u_ram (
        .clk  (clk),
        .we   (wready_q & wvalid),
        .addr (ptr),
        .wdata(wdata),
        .rdata(ram_q)
    );

    // awready_q doubles as "IDLE and out of reset", so handshakes start one cycle after rstn rises
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat      <= IDLE;
            ptr       <= '0;
            len       <= '0;
            cnt       <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid    <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            wlast_err <= 1'b0;
        end else begin
            wlast_err <= 1'b0;
            case (stat)
                IDLE: begin
                    if (awready_q && awvalid) begin
                        ptr       <= awaddr[D_LEVEL+:MEM_AWIDTH];
                        len       <= awlen;
                        cnt       <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        stat      <= WR;
                    end else if (awready_q && arvalid) begin
                        ptr       <= araddr[D_LEVEL+:MEM_AWIDTH];
                        len       <= arlen;
                        cnt       <= '0;
                        awready_q <= 1'b0;
                        stat      <= RFETCH;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                WR: begin
                    if (wvalid) begin
                        ptr       <= ptr + 1'b1;
                        cnt       <= cnt + 1'b1;
                        wlast_err <= wlast != (cnt == len);
                        if (cnt == len) begin
                            wready_q <= 1'b0;
                            bvalid   <= 1'b1;
                            stat     <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (bready) begin
                        bvalid    <= 1'b0;
                        awready_q <= 1'b1;
                        stat      <= IDLE;
                    end
                end
                RFETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= cnt == len;
                    stat     <= RDATA;
                end
                RDATA: begin
                    if (rready) begin
                        ptr       <= ptr + 1'b1;
                        cnt       <= cnt + 1'b1;
                        rvalid_q  <= 1'b0;
                        rlast_q   <= 1'b0;
                        awready_q <= rlast_q;
                        stat      <= rlast_q ? IDLE : RFETCH;
                    end
                end
                default: stat <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: randomized AXI bursts against a word-array model of a 16-word RAM
module tb_axi_ram_slave;
    logic        rstn, clk;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast, wlast_err;
    logic [25:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [15:0] wdata, rdata;
    logic [15:0] mem_m [16];
    bit          known [16];
    int          tests, fails;

    axi_ram_slave #(.A_WIDTH(26), .D_WIDTH(16), .D_LEVEL(1), .MEM_AWIDTH(4)) dut (
        .rstn(rstn), .clk(clk),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .wlast_err(wlast_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word lands in bits [4:1]; everything else is random to exercise aliasing
    function automatic logic [25:0] addr_of(input int word);
        logic [25:0] a;
        a = 26'($urandom);
        a[4:1] = word[3:0];
        return a;
    endfunction

    task automatic axi_write(input int word, input int len, input int bad, input int bd, input bit seq);
        logic [15:0] d [256];
        int i, t, errs, ars, exp_errs;
        for (int k = 0; k <= len; k++) d[k] = seq ? 16'(2 * k) : 16'($urandom);
        exp_errs = (bad >= 0 && bad <= len) ? 1 : 0;
        errs = 0; ars = 0; t = 0;
        awaddr = addr_of(word); awlen = 8'(len); awvalid = 1'b1;
        do begin @(negedge clk); ars += int'(arready); t++; end while (!awready && t < 50);
        tests++;
        if (!awready) begin fails++; $display("FAIL aw_timeout: awready=%b want 1", awready); awvalid = 1'b0; return; end
        @(posedge clk) #1;
        awvalid = 1'b0; wvalid = 1'b1; wdata = d[0]; wlast = (0 == len) ^ (0 == bad);
        i = 0; t = 0;
        while (i <= len && t < 400) begin
            @(negedge clk); t++;
            errs += int'(wlast_err); ars += int'(arready);
            if (wready) begin mem_m[(word + i) % 16] = d[i]; known[(word + i) % 16] = 1; i++; end
            @(posedge clk) #1;
            wdata = (i <= len) ? d[i] : 16'($urandom);
            wlast = (i <= len) ? ((i == len) ^ (i == bad)) : 1'b0;
        end
        tests++;
        if (i <= len) begin fails++; $display("FAIL w_timeout: beats=%0d want %0d", i, len + 1); end
        @(negedge clk);
        errs += int'(wlast_err);
        tests++;
        if (bvalid !== 1'b1 || wready !== 1'b0) begin
            fails++; $display("FAIL b_after_last: bvalid=%b wready=%b want 1 0", bvalid, wready);
        end
        @(posedge clk) #1 wvalid = 1'b0;
        repeat (bd) begin
            @(negedge clk);
            errs += int'(wlast_err); ars += int'(arready);
            tests++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                fails++; $display("FAIL b_hold: bvalid=%b awready=%b want 1 0", bvalid, awready);
            end
            @(posedge clk) #1;
        end
        bready = 1'b1;
        @(negedge clk);
        errs += int'(wlast_err); ars += int'(arready);
        @(posedge clk) #1 bready = 1'b0;
        tests++;
        if (errs !== exp_errs) begin fails++; $display("FAIL wlast_err_count: got %0d want %0d", errs, exp_errs); end
        tests++;
        if (ars !== 0) begin fails++; $display("FAIL arready_during_write: got %0d cycles want 0", ars); end
    endtask

    task automatic axi_read(input int word, input int len, input bit rand_rdy);
        int i, t;
        araddr = addr_of(word); arlen = 8'(len); arvalid = 1'b1; rready = 1'b0; t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        tests++;
        if (!arready) begin fails++; $display("FAIL ar_timeout: arready=%b want 1", arready); arvalid = 1'b0; return; end
        @(posedge clk) #1 arvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (rvalid !== 1'b0) begin fails++; $display("FAIL lat_t1: rvalid=%b want 0", rvalid); end
        @(posedge clk) #1 rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        tests++;
        if (rvalid !== 1'b1) begin fails++; $display("FAIL lat_t2: rvalid=%b want 1", rvalid); end
        i = 0; t = 0;
        while (i <= len && t < 400) begin
            if (rvalid) begin
                if (known[(word + i) % 16]) begin
                    tests++;
                    if (rdata !== mem_m[(word + i) % 16]) begin
                        fails++; $display("FAIL rdata beat %0d: got %h want %h", i, rdata, mem_m[(word + i) % 16]);
                    end
                end
                tests++;
                if (rlast !== (i == len)) begin fails++; $display("FAIL rlast beat %0d: got %b want %b", i, rlast, i == len); end
                if (rready) i++;
            end
            @(posedge clk) #1 rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk); t++;
        end
        tests++;
        if (i <= len) begin fails++; $display("FAIL r_timeout: beats=%0d want %0d", i, len + 1); end
        tests++;
        if (rvalid !== 1'b0 || awready !== 1'b1) begin
            fails++; $display("FAIL r_end_idle: rvalid=%b awready=%b want 0 1", rvalid, awready);
        end
        @(posedge clk) #1 rready = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({awready, arready, wready, bvalid, rvalid, rlast, wlast_err} !== 7'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 0000000", {awready, arready, wready, bvalid, rvalid, rlast, wlast_err});
        end
        tests++;
        if (rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        @(posedge clk) #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            fails++; $display("FAIL post_reset_ready: awready=%b arready=%b want 1 1", awready, arready);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_basic;
        wvalid = 1'b1; wdata = 16'hdead;
        @(negedge clk);
        tests++;
        if (wready !== 1'b0) begin fails++; $display("FAIL w_before_aw: wready=%b want 0", wready); end
        @(posedge clk) #1 wvalid = 1'b0;
        axi_write(0, 7, -1, 0, 1'b1);
        axi_read(0, 7, 1'b0);
    endtask

    task automatic test_collision;
        arvalid = 1'b1; araddr = addr_of(0); arlen = 8'd7;
        axi_write(0, 7, -1, 3, 1'b0);
        axi_read(0, 7, 1'b0);
    endtask

    task automatic test_wlast_err;
        axi_write(8, 3, 1, 1, 1'b0);
        axi_read(8, 3, 1'b1);
    endtask

    task automatic test_wrap;
        axi_write(14, 3, -1, 0, 1'b0);
        axi_read(14, 3, 1'b1);
        axi_read(0, 1, 1'b0);
    endtask

    task automatic test_stall_reset;
        int t;
        logic [15:0] snap;
        logic sl;
        araddr = addr_of(2); arlen = 8'd7; arvalid = 1'b1; rready = 1'b0; t = 0;
        do begin @(negedge clk); t++; end while (!arready && t < 50);
        @(posedge clk) #1 arvalid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!rvalid && t < 50);
        @(posedge clk) #1 rready = 1'b1;
        @(posedge clk) #1 rready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!rvalid && t < 50);
        snap = rdata; sl = rlast;
        tests++;
        if (snap !== mem_m[3] || sl !== 1'b0) begin
            fails++; $display("FAIL stall_first: rdata=%h rlast=%b want %h 0", snap, sl, mem_m[3]);
        end
        repeat (5) begin
            @(posedge clk) #1;
            @(negedge clk);
            tests++;
            if (rvalid !== 1'b1 || rdata !== snap || rlast !== sl) begin
                fails++; $display("FAIL stall_stable: rvalid=%b rdata=%h rlast=%b want 1 %h %b", rvalid, rdata, rlast, snap, sl);
            end
        end
        @(posedge clk) #1 rstn = 1'b0;
        #1;
        tests++;
        if (rvalid !== 1'b0 || rdata !== 16'h0 || rlast !== 1'b0) begin
            fails++; $display("FAIL async_reset: rvalid=%b rdata=%h rlast=%b want 0 0000 0", rvalid, rdata, rlast);
        end
        @(posedge clk) #1 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (awready !== 1'b1 || rvalid !== 1'b0) begin
            fails++; $display("FAIL restart_idle: awready=%b rvalid=%b want 1 0", awready, rvalid);
        end
        @(posedge clk) #1;
    endtask

    task automatic test_random;
        int word, len, bad;
        for (int n = 0; n < 30; n++) begin
            word = $urandom_range(0, 15);
            len  = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) begin
                bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
                axi_write(word, len, bad, $urandom_range(0, 3), 1'b0);
            end else begin
                axi_read(word, len, 1'b1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0; fails = 0;
        awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wlast = 0; wdata = '0; bready = 0;
        arvalid = 0; araddr = '0; arlen = '0; rready = 0;
        test_reset();
        test_basic();
        test_collision();
        test_wlast_err();
        test_wrap();
        test_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
